// File: rtl/fetch_unit.sv
// Instruction fetch PC sequencer: sequential advance, squash-and-redirect, pending redirect, halt.
// Optional macro FETCH_PERF_CNT_EN adds the fetch_count performance counter output.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic [31:0] NPC,
  output logic        fetch_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_reg;
  logic        ren;

  // Instruction addresses are word aligned; the low two target bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign imemaddr    = pc;
  assign NPC         = pc + 32'd4;
  assign imemREN     = ren;
  assign fetch_valid = (state == RUN) && ihit && !stall && !redirect && !halt && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc        <= PC_INIT;
      state     <= RUN;
      redir_reg <= 32'd0;
      ren       <= 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
            ren   <= 1'b0;
          end else if (redirect) begin
            // A taken redirect squashes the current fetch regardless of stall.
            if (ihit) begin
              pc <= align_word(redirect_pc);
            end else begin
              redir_reg <= align_word(redirect_pc);
              state     <= REDIR_PEND;
            end
          end else if (ihit && !stall) begin
            pc <= pc + 32'd4;
          end
        end
        REDIR_PEND: begin
          if (halt) begin
            state <= HALTED;
            ren   <= 1'b0;
          end else if (redirect) begin
            redir_reg <= align_word(redirect_pc);
            if (ihit) begin
              pc    <= align_word(redirect_pc);
              state <= RUN;
            end
          end else if (ihit) begin
            pc    <= redir_reg;
            state <= RUN;
          end
        end
        HALTED: begin
          ren <= 1'b0;
        end
        default: begin
          state <= RUN;
          ren   <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;

  always_ff @(posedge CLK) begin
    if (RST)
      fetch_cnt <= 32'd0;
    else if (fetch_valid)
      fetch_cnt <= fetch_cnt + 32'd1;
  end

  assign fetch_count = fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each cycle applies inputs and checks PC, NPC, read enable, valid.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imemaddr;
  logic        imemREN;
  logic [31:0] NPC;
  logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imemaddr    (imemaddr),
    .imemREN     (imemREN),
    .NPC         (NPC),
    .fetch_valid (fetch_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then check outputs before the next rising edge.
  task automatic cyc(input logic r, input logic ih, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic h,
                     input logic [31:0] exp_addr, input logic exp_ren, input logic exp_fv,
                     input string tag);
    @(negedge CLK);
    RST = r; ihit = ih; stall = st; redirect = rd; redirect_pc = rpc; halt = h;
    #1;
    check_val({tag, ".imemaddr"}, imemaddr, exp_addr);
    check_val({tag, ".NPC"}, NPC, exp_addr + 32'd4);
    check_val({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, exp_ren});
    check_val({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
`ifdef FETCH_PERF_CNT_EN
    check_val({tag, ".fetch_count"}, fetch_count, exp_cnt);
`endif
    if (r) exp_cnt = 0;
    else if (exp_fv) exp_cnt++;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;

    // Reset overrides valid, redirect and halt.
    cyc(1, 1, 0, 1, 32'h500, 0, 32'h0, 1, 0, "rst_redir");
    cyc(1, 1, 0, 0, 32'h0,   1, 32'h0, 1, 0, "rst_halt");

    // Sequential fetch from PC_INIT.
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 1, "seq0");
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h4, 1, 1, "seq1");
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h8, 1, 1, "seq2");
    cyc(0, 1, 0, 0, 32'h0, 0, 32'hC, 1, 1, "seq3");

    // Stall holds the PC and suppresses valid; ihit=0 also holds.
    cyc(0, 1, 1, 0, 32'h0, 0, 32'h10, 1, 0, "stall0");
    cyc(0, 1, 1, 0, 32'h0, 0, 32'h10, 1, 0, "stall1");
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h10, 1, 1, "stall_rel");
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h14, 1, 0, "nohit");
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h14, 1, 1, "nohit_held");

    // Redirect with ihit: squash, load aligned target next cycle, stall ignored.
    cyc(0, 1, 0, 1, 32'h20,  0, 32'h18,  1, 0, "redir_to20");
    cyc(0, 1, 1, 1, 32'h103, 0, 32'h20,  1, 0, "redir_103");
    cyc(0, 1, 0, 0, 32'h0,   0, 32'h100, 1, 1, "after_redir");
    cyc(0, 1, 0, 1, 32'h20,  0, 32'h104, 1, 0, "redir_back20");

    // Redirect without ihit: pending, overwritten, then taken on ihit.
    cyc(0, 0, 0, 1, 32'h200, 0, 32'h20,  1, 0, "pend0");
    cyc(0, 0, 0, 1, 32'h302, 0, 32'h20,  1, 0, "pend_ovr");
    cyc(0, 1, 0, 0, 32'h0,   0, 32'h20,  1, 0, "pend_hit");
    cyc(0, 1, 0, 0, 32'h0,   0, 32'h300, 1, 1, "pend_done");

    // New redirect coincident with ihit while pending loads the new target.
    cyc(0, 0, 0, 1, 32'h400, 0, 32'h304, 1, 0, "pend2");
    cyc(0, 1, 0, 1, 32'h500, 0, 32'h304, 1, 0, "pend2_hit");
    cyc(0, 1, 0, 0, 32'h0,   0, 32'h500, 1, 1, "pend2_done");

    // Halt beats redirect; HALTED is absorbing for 10 cycles.
    cyc(0, 1, 0, 1, 32'h40, 0, 32'h504, 1, 0, "redir_to40");
    cyc(0, 1, 0, 1, 32'h80, 1, 32'h40,  1, 0, "halt_redir");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, i[0], ~i[0], 32'h900, i[1], 32'h40, 0, 0, "halted");
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h40, 0, 0, "rst_from_halt");
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h0,  1, 0, "post_halt_rst");

    // Reset from REDIR_PEND behaves like reset from RUN.
    cyc(0, 0, 0, 1, 32'h600, 0, 32'h0, 1, 0, "pend_pre_rst");
    cyc(1, 0, 0, 0, 32'h0,   0, 32'h0, 1, 0, "rst_from_pend");
    cyc(0, 1, 0, 0, 32'h0,   0, 32'h0, 1, 1, "post_pend_rst");

    // PC wrap at the top of the address space.
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h4,         1, 0, "redir_top");
    cyc(0, 1, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 1, "top");
    cyc(0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 1, "wrapped");
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h4,         1, 0, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_INIT, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 ihit  input  1  instruction memory access for imemaddr complete this cycle.
REQ-005 stall  input  1  hazard-unit hold; blocks sequential PC advance, same signal that holds the IF/ID latch.
REQ-006 redirect  input  1  branch/jump resolved taken; load redirect_pc.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 halt  input  1  halt instruction decoded; stop fetching.
REQ-009 imemaddr  output  32  current PC driven to instruction memory.
REQ-010 imemREN  output  1  instruction memory read enable.
REQ-011 NPC  output  32  PC+4 of current fetch, consumed by IF/ID latch.
REQ-012 fetch_valid  output  1  current imemload is a valid, non-squashed instruction to latch.

Function
REQ-013 States: RUN, REDIR_PEND, HALTED; 2-bit encoded state register.
REQ-014 imemaddr SHALL equal PC register; NPC SHALL equal PC+4 modulo 2^32 (0xFFFF_FFFC -> NPC 0x0000_0000).
REQ-015 imemREN SHALL be 1 in RUN and REDIR_PEND, 0 in HALTED.
REQ-016 fetch_valid SHALL be 1 only when state=RUN and ihit=1 and stall=0 and redirect=0 and halt=0 and RST=0.
REQ-017 RUN, no redirect/halt: ihit=1 and stall=0 -> PC<=PC+4 next cycle; otherwise PC held.
REQ-018 RUN, redirect=1 and ihit=1 -> PC<=redirect_pc, stay RUN; current instruction squashed (fetch_valid=0); stall ignored.
REQ-019 RUN, redirect=1 and ihit=0 -> target captured in redir_reg, PC held, go REDIR_PEND.
REQ-020 REDIR_PEND: fetch_valid=0; on ihit=1 -> PC<=redir_reg, go RUN; new redirect in REDIR_PEND overwrites redir_reg, and if coincident with ihit the new redirect_pc is loaded.
REQ-021 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into PC or redir_reg.
REQ-022 halt=1 in RUN or REDIR_PEND -> HALTED next cycle, PC held; halt has priority over redirect and sequential advance.
REQ-023 HALTED is absorbing: PC frozen, all inputs except RST ignored.
REQ-024 Latency: redirect taken at cycle N with ihit=1 -> imemaddr=target at cycle N+1.

Reset
REQ-025 RST=1 at rising edge -> PC<=PC_INIT, state<=RUN, redir_reg<=0, overriding any concurrent redirect/halt/pending redirect.
REQ-026 After reset: imemaddr=PC_INIT, NPC=PC_INIT+4, imemREN=1, fetch_valid=0 while RST=1.
REQ-027 Reset from HALTED or REDIR_PEND SHALL behave identically to reset from RUN.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: adds output fetch_count (32 bits), zeroed on reset, incremented each cycle fetch_valid=1, wraps 0xFFFF_FFFF -> 0.
REQ-029 FETCH_PERF_CNT_EN undefined: fetch_count port and counter absent; all other behaviour identical.

Verification
REQ-030 Reset with PC_INIT=0, then ihit=1, stall=0 for 3 cycles -> imemaddr 0x0,0x4,0x8, NPC 0x4,0x8,0xC, fetch_valid=1 each.
REQ-031 PC=0x10, stall=1 ihit=1 for 2 cycles -> imemaddr stays 0x10, fetch_valid=0; stall release -> 0x14 next cycle.
REQ-032 PC=0x20, redirect=1 redirect_pc=0x103 ihit=1 -> fetch_valid=0, next imemaddr=0x100, state RUN.
REQ-033 PC=0x20, ihit=0 redirect=1 redirect_pc=0x200; next cycle ihit=0 redirect=1 redirect_pc=0x300; then ihit=1 -> imemaddr=0x300 after, fetch_valid=0 throughout REDIR_PEND.
REQ-034 halt=1 and redirect=1 same cycle at PC=0x40 -> HALTED, imemREN=0, imemaddr=0x40 held 10 cycles; RST=1 -> imemaddr=PC_INIT, imemREN=1.
REQ-035 PC=0xFFFF_FFFC, ihit=1 -> NPC=0x0, next imemaddr=0x0; with FETCH_PERF_CNT_EN, fetch_count equals number of fetch_valid cycles since reset.
